// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LATENCY    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1 || MAX_STREAK < 1) begin : g_cfg_err
    $error("mem_arbiter: LATENCY and MAX_STREAK must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          own_dm;
  logic          we_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          done;
  logic          can_gnt;
  logic          pick_dm;

  // Last WAIT cycle: data is on mem_rdata and the port is free again.
  assign done    = (state == WAIT) && (cnt == '0);
  assign can_gnt = rst_n && ((state == IDLE) || done);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak;

  assign pick_dm = dm_req &&
                   !(if_req && (streak == SW'(MAX_STREAK)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (dm_gnt) begin
      streak <= if_req ? streak + 1'b1 : '0;
    end else if (if_gnt) begin
      streak <= '0;
    end
  end
`else
  assign pick_dm = dm_req;
`endif

  assign dm_gnt = can_gnt && pick_dm;
  assign if_gnt = can_gnt && if_req && !pick_dm;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (if_gnt || dm_gnt) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (done) state_nx = (if_gnt || dm_gnt) ? ISSUE : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      own_dm     <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == ISSUE) begin
        cnt <= CW'(LATENCY - 1);
      end else if ((state == WAIT) && !done) begin
        cnt <= cnt - 1'b1;
      end
      if (done && !own_dm) if_rdata_q <= mem_rdata;
      if (done && own_dm && !we_q) dm_rdata_q <= mem_rdata;
      if (dm_gnt) begin
        own_dm    <= 1'b1;
        we_q      <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (if_gnt) begin
        own_dm   <= 1'b0;
        we_q     <= 1'b0;
        mem_addr <= if_addr;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign mem_en   = (state == ISSUE);
  assign mem_we   = mem_en && we_q;
  assign if_valid = done && !own_dm;
  assign dm_valid = done && own_dm;
  // Completion data is forwarded straight through in its valid cycle.
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign dm_rdata = (dm_valid && !we_q) ? mem_rdata : dm_rdata_q;

endmodule
